fpadd_result_stage: RTL and testbench
=====================================

Name: fpadd_result_stage

Overview:
- Registered downstream stage for the combinational shared FP32 / dual-bf16 adder.
- Takes the adder's raw packed result together with the original operands and format.
- Applies per-lane IEEE special-case fix-up (NaN, Inf, zero, exact cancellation, exponent overflow/underflow), because the adder datapath has no exception handling.
- Buffers results in a 2-entry valid/ready FIFO and keeps sticky exception flags.

Parameters:
- DEPTH, 2, output FIFO entries (fixed at 2; other values unsupported).
- QNAN32, 32'h7FC00000, canonical FP32 quiet NaN.
- QNAN16, 16'h7FC0, canonical bf16 quiet NaN.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands and adder result are valid this cycle.
- in_ready  output  1  stage can accept an entry.
- fmt  input  fp_fmt_e  FP32, or FP16 meaning two bf16 lanes hi[31:16] and lo[15:0].
- op_x  input  32  adder operand X, same cycle as add_r.
- op_y  input  32  adder operand Y.
- add_r  input  32  raw adder result for op_x/op_y/fmt.
- out_valid  output  1  out_* fields hold a result.
- out_ready  input  1  consumer accepts the result.
- out_fmt  output  fp_fmt_e  format of the result.
- out_r  output  32  fixed-up result.
- out_flags  output  6  {nv_h,of_h,uf_h,nv_l,of_l,uf_l}; in FP32 only the _h bits are used and the _l bits read 0.
- flags_acc  output  6  sticky OR of flags for every accepted entry.
- flags_clr  input  1  clear flags_acc.

Behaviour:
- Reset is asynchronous and active-high: FIFO empty, out_valid=0, out_r=0, out_flags=0, out_fmt=FP32, flags_acc=0, in_ready=1 once rst deasserts. Reset mid-transfer drops all entries.
- Push fires when in_valid && in_ready. Pop fires when out_valid && out_ready.
- in_ready = (count<2), a registered-count function that is independent of out_ready (no combinational ready path).
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. Order is strict FIFO.
- Count transitions:
  - count 1 with push and pop: stays at 1, new entry queued.
  - count 2: no push possible.
  - count 0 with pop: impossible.
- out_* fields are driven from the head entry and hold stable while out_valid && !out_ready.
- Lane fields:
  - FP32 lane: exp [30:23], frac [22:0].
  - bf16 lane: exp [14:7], frac [6:0], within each 16-bit half.
- Per-lane classification of an operand:
  - exp==0: zero (subnormals flushed).
  - exp==255, frac==0: Inf.
  - exp==255, frac!=0: NaN; sNaN when the frac MSB is 0.
- Per-lane fix-up, first match wins:
  1. Either operand NaN: result is the canonical qNaN; nv=1 if either operand is sNaN.
  2. Both Inf with opposite signs: qNaN, nv=1.
  3. Either operand Inf: that Inf.
  4. Both zero: zero with sign = sx & sy.
  5. One zero: the other operand unchanged.
  6. Equal magnitude, opposite signs: +0.
  7. add_r lane exp==255: Inf with the add_r lane sign, of=1.
  8. add_r lane exp==0: signed zero with the add_r lane sign, uf=1.
  9. Otherwise: add_r lane passes through.
- In FP16 mode the two lanes are evaluated independently.
- Fix-up is combinational before the FIFO write; flags are stored with the entry.
- flags_acc updates on push: flags_acc <= (flags_clr ? 0 : flags_acc) | push_flags. The clear acts on old state; flags from a same-cycle push survive.

Test Plan:
- FP32, X=3F800000, Y=40000000, add_r=40400000, out_ready=1 -> next cycle out_valid=1, out_r=40400000, out_flags=0.
- FP16, X=7F80_3F80, Y=FF80_3F80, add_r=1234_4000 -> out_r=7FC0_4000, out_flags=6'b100000, flags_acc=6'b100000.
- FP32, X=40490FDB, Y=C0490FDB, add_r=00800000 -> out_r=00000000, flags 0.
- FP32, X=Y=7F7FFFFF, add_r=7F800000 -> out_r=7F800000, of_h=1. FP16 lo lane with add_r lo=8000 (exp 0, X/Y nonzero and non-cancelling) -> lo=8000, uf_l=1.
- Backpressure: out_ready=0, drive 3 consecutive valid inputs A, B, C -> A and B accepted, in_ready=0 on the third cycle, out_r holds A. Then out_ready=1 -> A, B out in order, C accepted after the first pop.
- Reset and clear:
  - rst asserted with count=2 -> out_valid drops immediately, flags_acc=0.
  - flags_clr on the same cycle as a push of an NV-flagged entry -> flags_acc equals that entry's flags only.

Source files
------------

// File: rtl/fpadd_result_stage.sv
// Registered result stage for the shared FP32 / dual-bf16 adder: per-lane IEEE
// special-case fix-up followed by a 2-entry valid/ready FIFO with sticky flags.
package fpadd_result_pkg;
  typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fp_fmt_e;
endpackage

module fpadd_result_stage
  import fpadd_result_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter logic [31:0] QNAN32 = 32'h7FC00000,
  parameter logic [15:0] QNAN16 = 16'h7FC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  fp_fmt_e     fmt,
  input  logic [31:0] op_x,
  input  logic [31:0] op_y,
  input  logic [31:0] add_r,
  output logic        out_valid,
  input  logic        out_ready,
  output fp_fmt_e     out_fmt,
  output logic [31:0] out_r,
  output logic [5:0]  out_flags,
  output logic [5:0]  flags_acc,
  input  logic        flags_clr
);

  typedef struct packed {
    logic [31:0] res;
    logic        nv;
    logic        of;
    logic        uf;
  } lane_t;

  typedef struct packed {
    fp_fmt_e     fmt;
    logic [31:0] r;
    logic [5:0]  flags;
  } entry_t;

  // Operates on an FP32-shaped word; a bf16 lane is passed left-aligned with
  // zero padding, so its result lands in [31:16] and [15:0] stays zero.
  function automatic lane_t fix_lane(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] r, input logic [31:0] qnan);
    lane_t o;
    logic  x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    x_inf  = (&x[30:23]) && (x[22:0] == 23'h0);
    y_inf  = (&y[30:23]) && (y[22:0] == 23'h0);
    x_nan  = (&x[30:23]) && (|x[22:0]);
    y_nan  = (&y[30:23]) && (|y[22:0]);
    x_snan = x_nan && !x[22];
    y_snan = y_nan && !y[22];
    o = '{res: r, nv: 1'b0, of: 1'b0, uf: 1'b0};
    if (x_nan || y_nan) begin
      o.res = qnan;
      o.nv  = x_snan || y_snan;
    end else if (x_inf && y_inf && (x[31] != y[31])) begin
      o.res = qnan;
      o.nv  = 1'b1;
    end else if (x_inf) begin
      o.res = x;
    end else if (y_inf) begin
      o.res = y;
    end else if (x_zero && y_zero) begin
      o.res = {x[31] & y[31], 31'h0};
    end else if (x_zero) begin
      o.res = y;
    end else if (y_zero) begin
      o.res = x;
    end else if ((x[30:0] == y[30:0]) && (x[31] != y[31])) begin
      o.res = '0;
    end else if (&r[30:23]) begin
      o.res = {r[31], 8'hFF, 23'h0};
      o.of  = 1'b1;
    end else if (r[30:23] == 8'h00) begin
      o.res = {r[31], 31'h0};
      o.uf  = 1'b1;
    end
    return o;
  endfunction

  lane_t       lane32, lane_hi, lane_lo;
  entry_t      new_entry;
  entry_t      mem [DEPTH];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        push, pop;

  always_comb begin
    lane32  = fix_lane(op_x, op_y, add_r, QNAN32);
    lane_hi = fix_lane({op_x[31:16], 16'h0}, {op_y[31:16], 16'h0},
                       {add_r[31:16], 16'h0}, {QNAN16, 16'h0});
    lane_lo = fix_lane({op_x[15:0], 16'h0}, {op_y[15:0], 16'h0},
                       {add_r[15:0], 16'h0}, {QNAN16, 16'h0});
    new_entry.fmt = fmt;
    if (fmt == FP32) begin
      new_entry.r     = lane32.res;
      new_entry.flags = {lane32.nv, lane32.of, lane32.uf, 3'b000};
    end else begin
      // Both padded lane results have zero low halves, so OR-merging packs them.
      new_entry.r     = lane_hi.res | (lane_lo.res >> 16);
      new_entry.flags = {lane_hi.nv, lane_hi.of, lane_hi.uf,
                         lane_lo.nv, lane_lo.of, lane_lo.uf};
    end
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_fmt   = mem[rd_ptr].fmt;
  assign out_r     = mem[rd_ptr].r;
  assign out_flags = mem[rd_ptr].flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
      flags_acc <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      flags_acc <= (flags_clr ? 6'h00 : flags_acc) | (push ? new_entry.flags : 6'h00);
    end
  end

endmodule

// File: tb/tb_fpadd_result_stage.sv
// Directed bench for fpadd_result_stage: literal expectations plus a per-cycle
// comparison against a rule-level model of the fix-up and FIFO.
module tb_fpadd_result_stage;
  import fpadd_result_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  fp_fmt_e     fmt = FP32;
  logic [31:0] op_x = '0, op_y = '0, add_r = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  fp_fmt_e     out_fmt;
  logic [31:0] out_r;
  logic [5:0]  out_flags, flags_acc;
  logic        flags_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  fpadd_result_stage #(.DEPTH(2), .QNAN32(32'h7FC00000), .QNAN16(16'h7FC0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .op_x(op_x), .op_y(op_y), .add_r(add_r), .out_valid(out_valid),
    .out_ready(out_ready), .out_fmt(out_fmt), .out_r(out_r), .out_flags(out_flags),
    .flags_acc(flags_acc), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  typedef enum {C_ZERO, C_NORM, C_INF, C_QNAN, C_SNAN} cls_e;
  typedef struct {
    fp_fmt_e   fmt;
    bit [31:0] r;
    bit [5:0]  fl;
  } ent_t;

  ent_t     q[$];
  bit [5:0] acc_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic cls_e classify(input bit [31:0] v, input int fw);
    bit [31:0] one = 1;
    bit [31:0] e = (v >> fw) & 32'hFF;
    bit [31:0] f = v & ((one << fw) - 1);
    if (e == 0) return C_ZERO;
    if (e != 255) return C_NORM;
    if (f == 0) return C_INF;
    return ((f >> (fw - 1)) & 1) != 0 ? C_QNAN : C_SNAN;
  endfunction

  // One lane: wide=1 is FP32 in [31:0], wide=0 is bf16 in [15:0].
  function automatic void lane_model(input bit wide, input bit [31:0] x, input bit [31:0] y,
                                     input bit [31:0] r, output bit [31:0] res,
                                     output bit [2:0] fl);
    int        fw = wide ? 23 : 7;
    int        sb = wide ? 31 : 15;
    bit [31:0] one = 1;
    bit [31:0] smask = one << sb;
    bit [31:0] mmask = smask - 1;
    bit [31:0] qn = wide ? 32'h7FC00000 : 32'h00007FC0;
    cls_e      cx = classify(x, fw);
    cls_e      cy = classify(y, fw);
    bit        sx = (x & smask) != 0;
    bit        sy = (y & smask) != 0;
    bit [31:0] re = (r >> fw) & 32'hFF;
    fl = 3'b000;
    if (cx inside {C_QNAN, C_SNAN} || cy inside {C_QNAN, C_SNAN}) begin
      res = qn;
      fl[2] = (cx == C_SNAN) || (cy == C_SNAN);
    end else if (cx == C_INF && cy == C_INF && sx != sy) begin
      res = qn;
      fl[2] = 1'b1;
    end else if (cx == C_INF) res = x;
    else if (cy == C_INF) res = y;
    else if (cx == C_ZERO && cy == C_ZERO) res = (sx && sy) ? smask : 0;
    else if (cx == C_ZERO) res = y;
    else if (cy == C_ZERO) res = x;
    else if ((x & mmask) == (y & mmask) && sx != sy) res = 0;
    else if (re == 255) begin
      res = (r & smask) | (32'hFF << fw);
      fl[1] = 1'b1;
    end else if (re == 0) begin
      res = r & smask;
      fl[0] = 1'b1;
    end else res = r;
  endfunction

  function automatic ent_t model(input fp_fmt_e f, input bit [31:0] x, input bit [31:0] y,
                                 input bit [31:0] r);
    ent_t      e;
    bit [31:0] rh, rl;
    bit [2:0]  fh, fl;
    e.fmt = f;
    if (f == FP32) begin
      lane_model(1'b1, x, y, r, rh, fh);
      e.r  = rh;
      e.fl = {fh, 3'b000};
    end else begin
      lane_model(1'b0, x >> 16, y >> 16, r >> 16, rh, fh);
      lane_model(1'b0, x & 32'hFFFF, y & 32'hFFFF, r & 32'hFFFF, rl, fl);
      e.r  = {rh[15:0], rl[15:0]};
      e.fl = {fh, fl};
    end
    return e;
  endfunction

  // Compare process: inputs are stable at the negedge, so after checking the
  // model is advanced to the state the next posedge will produce.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc_m = '0;
    end else begin
      int   n;
      bit   pushm;
      ent_t e;
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk("flags_acc", {26'b0, flags_acc}, {26'b0, acc_m});
      if (q.size() != 0) begin
        chk("out_r", out_r, q[0].r);
        chk("out_flags", {26'b0, out_flags}, {26'b0, q[0].fl});
        chk("out_fmt", 32'(out_fmt), 32'(q[0].fmt));
      end
      n = q.size();
      pushm = in_valid && (n < 2);
      if (pushm) e = model(fmt, op_x, op_y, add_r);
      if (n > 0 && out_ready) void'(q.pop_front());
      if (pushm) q.push_back(e);
      acc_m = (flags_clr ? 6'h00 : acc_m) | (pushm ? e.fl : 6'h00);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input fp_fmt_e f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r);
    in_valid = 1'b1;
    fmt = f;
    op_x = x;
    op_y = y;
    add_r = r;
  endtask

  task automatic send_check(input string name, input fp_fmt_e f, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] r,
                            input logic [31:0] exp_r, input logic [5:0] exp_fl);
    drive(f, x, y, r);
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_r"}, out_r, exp_r);
    chk({name, "_flags"}, {26'b0, out_flags}, {26'b0, exp_fl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_r", out_r, 32'h0);
    chk("rst_out_flags", {26'b0, out_flags}, 32'd0);
    chk("rst_out_fmt", 32'(out_fmt), 32'(FP32));
    chk("rst_flags_acc", {26'b0, flags_acc}, 32'd0);
    step();

    send_check("fp32_add", FP32, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40400000, 6'b000000);
    send_check("bf16_inf", FP16, 32'h7F803F80, 32'hFF803F80, 32'h12344000, 32'h7FC04000, 6'b100000);
    chk("bf16_inf_acc", {26'b0, flags_acc}, 32'h20);
    send_check("cancel", FP32, 32'h40490FDB, 32'hC0490FDB, 32'h00800000, 32'h00000000, 6'b000000);
    send_check("overflow", FP32, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 6'b010000);
    send_check("bf16_uf", FP16, 32'h3F803F80, 32'h3F80BF00, 32'h40008000, 32'h40008000, 6'b000001);
    send_check("snan", FP32, 32'h7F800001, 32'h3F800000, 32'h7F800001, 32'h7FC00000, 6'b100000);
    send_check("qnan", FP32, 32'h3F800000, 32'hFFC00001, 32'h00000000, 32'h7FC00000, 6'b000000);
    send_check("zero_zero", FP32, 32'h80000000, 32'h80000000, 32'h12345678, 32'h80000000, 6'b000000);
    send_check("zero_one", FP32, 32'h00000000, 32'hC0A00000, 32'h12345678, 32'hC0A00000, 6'b000000);
    send_check("inf_fin", FP32, 32'h3F800000, 32'hFF800000, 32'h00000000, 32'hFF800000, 6'b000000);
    send_check("bf16_mix", FP16, 32'h00007F81, 32'hC1200000, 32'h00000000, 32'hC1207FC0, 6'b000100);
    step();

    // Backpressure: A and B fill the FIFO, C waits for the first pop.
    out_ready = 1'b0;
    drive(FP32, 32'h3F800000, 32'h3F800000, 32'h40000000);
    step();
    drive(FP32, 32'h40000000, 32'h40000000, 32'h40800000);
    step();
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_head_a", out_r, 32'h40000000);
    drive(FP32, 32'h40800000, 32'h40800000, 32'h41000000);
    step();
    chk("bp_hold_a", out_r, 32'h40000000);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_r, 32'h40800000);
    chk("bp_ready_after_pop", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_head_c", out_r, 32'h41000000);
    step();
    step();

    // Reset with the FIFO full and flags set.
    out_ready = 1'b0;
    drive(FP32, 32'h7F800001, 32'h3F800000, 32'h0);
    step();
    step();
    in_valid = 1'b0;
    chk("full_before_rst", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_acc", {26'b0, flags_acc}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_rel_ready", {31'b0, in_ready}, 32'd1);
    step();

    // Clear coinciding with a push keeps only the pushed entry's flags.
    send_check("clr_pre", FP32, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 6'b010000);
    chk("clr_pre_acc", {26'b0, flags_acc}, 32'h10);
    flags_clr = 1'b1;
    send_check("clr_push", FP32, 32'h7F800000, 32'hFF800000, 32'h0, 32'h7FC00000, 6'b100000);
    flags_clr = 1'b0;
    chk("clr_acc", {26'b0, flags_acc}, 32'h20);
    step();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
